wb_line_master: RTL and testbench

- Wishbone B4 burst master that sits directly upstream of wb_memory_controller.
- Converts one 16-byte cache-line request (fill or writeback) from a cache/core-side client into a 4-beat incrementing Wishbone burst.
- Assembles read beats into a 128-bit line; serialises write lines into beats with per-byte selects.
- Includes a per-beat ack watchdog so a stalled slave cannot hang the client.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_line_master.sv | 196 +++++++++++++++++++
 tb/tb_wb_line_master.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone burst constants and line-master state type
package wb_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam int LINE_WORDS = 4;
    localparam int LINE_BITS  = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/wb_line_master.sv
// rtl/wb_line_master.sv - 16-byte cache line to 4-beat incrementing Wishbone burst master
module wb_line_master
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    localparam int TO_W = $clog2(TIMEOUT + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [31:0]          i_addr,
    input  logic [LINE_BITS-1:0] i_data,
    input  logic [15:0]          i_strb,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [LINE_BITS-1:0] o_data,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [2:0]           o_wb_cti,
    output logic [1:0]           o_wb_bte,
    output logic [3:0]           o_wb_sel,
    output logic [31:0]          o_wb_addr,
    output logic [31:0]          o_wb_data,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err,
    input  logic [31:0]          i_wb_data
);

    state_t               r_state, w_state;
    logic                 r_we, w_we;
    logic [LINE_BITS-1:0] r_line, w_line;
    logic [15:0]          r_strb, w_strb;
    logic [1:0]           r_beat, w_beat;
    logic [TO_W-1:0]      r_wd, w_wd;
    logic                 r_cyc, w_cyc;
    logic                 r_stb, w_stb;
    logic                 r_wb_we, w_wb_we;
    logic [2:0]           r_cti, w_cti;
    logic [3:0]           r_sel, w_sel;
    logic [31:0]          r_addr, w_addr;
    logic [31:0]          r_wdata, w_wdata;
    logic                 r_busy, w_busy;
    logic                 r_done, w_done;
    logic                 r_err, w_err;
    logic [LINE_BITS-1:0] r_data, w_data;

    logic [1:0] w_next_beat;
    logic       w_beat_ack;
    logic       w_abort;
    logic       w_unused_addr;

    assign w_next_beat   = r_beat + 2'd1;
    assign w_unused_addr = ^i_addr[3:0];

    // err outranks a simultaneous ack; the watchdog only fires on a beat with neither
    assign w_beat_ack = r_stb & i_wb_ack & ~i_wb_err;
    assign w_abort    = r_stb & (i_wb_err |
                        (~i_wb_ack & (r_wd == TO_W'(TIMEOUT - 1))));

    always_comb begin
        w_state = r_state;
        w_we    = r_we;
        w_line  = r_line;
        w_strb  = r_strb;
        w_beat  = r_beat;
        w_wd    = r_wd;
        w_cyc   = r_cyc;
        w_stb   = r_stb;
        w_wb_we = r_wb_we;
        w_cti   = r_cti;
        w_sel   = r_sel;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_err   = r_err;
        w_data  = r_data;

        unique case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_state = ST_BURST;
                    w_we    = i_we;
                    w_line  = i_data;
                    w_strb  = i_strb;
                    w_beat  = 2'd0;
                    w_wd    = '0;
                    w_cyc   = 1'b1;
                    w_stb   = 1'b1;
                    w_wb_we = i_we;
                    w_cti   = CTI_INCR;
                    w_addr  = {i_addr[31:4], 4'h0};
                    w_sel   = i_we ? i_strb[3:0] : 4'hF;
                    w_wdata = i_we ? i_data[31:0] : 32'h0;
                    w_busy  = 1'b1;
                    w_err   = 1'b0;
                end
            end
            ST_BURST: begin
                if (w_abort) begin
                    w_state = ST_DONE;
                    w_cyc   = 1'b0;
                    w_stb   = 1'b0;
                    w_cti   = CTI_CLASSIC;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_err   = 1'b1;
                end else if (w_beat_ack) begin
                    w_wd = '0;
                    if (!r_we) begin
                        w_data[{r_beat, 5'd0} +: 32] = i_wb_data;
                    end
                    if (r_beat == 2'(LINE_WORDS - 1)) begin
                        w_state = ST_DONE;
                        w_cyc   = 1'b0;
                        w_stb   = 1'b0;
                        w_cti   = CTI_CLASSIC;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_beat  = w_next_beat;
                        w_addr  = r_addr + 32'd4;
                        w_cti   = (w_next_beat == 2'(LINE_WORDS - 1)) ? CTI_END : CTI_INCR;
                        w_sel   = r_we ? r_strb[{w_next_beat, 2'd0} +: 4] : 4'hF;
                        w_wdata = r_we ? r_line[{w_next_beat, 5'd0} +: 32] : 32'h0;
                    end
                end else begin
                    w_wd = r_wd + 1'b1;
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_line  <= '0;
            r_strb  <= '0;
            r_beat  <= '0;
            r_wd    <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_wb_we <= 1'b0;
            r_cti   <= CTI_CLASSIC;
            r_sel   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state;
            r_we    <= w_we;
            r_line  <= w_line;
            r_strb  <= w_strb;
            r_beat  <= w_beat;
            r_wd    <= w_wd;
            r_cyc   <= w_cyc;
            r_stb   <= w_stb;
            r_wb_we <= w_wb_we;
            r_cti   <= w_cti;
            r_sel   <= w_sel;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
            r_data  <= w_data;
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_data    = r_data;
    assign o_wb_cyc  = r_cyc;
    assign o_wb_stb  = r_stb;
    assign o_wb_we   = r_wb_we;
    assign o_wb_cti  = r_cti;
    assign o_wb_bte  = BTE_LINEAR;
    assign o_wb_sel  = r_sel;
    assign o_wb_addr = r_addr;
    assign o_wb_data = r_wdata;

endmodule

// File: tb/tb_wb_line_master.sv
// tb/tb_wb_line_master.sv - vector table plus scripted corner cases against a wait-state slave model
module tb_wb_line_master;
    import wb_pkg::*;

    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst, req, we;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  strb;
    logic         busy, done, err;
    logic [127:0] odata;
    logic         wb_cyc, wb_stb, wb_we;
    logic [2:0]   wb_cti;
    logic [1:0]   wb_bte;
    logic [3:0]   wb_sel;
    logic [31:0]  wb_addr, wb_wdata;
    logic         wb_ack, wb_err;
    logic [31:0]  wb_rdata;

    always #5 clk = ~clk;

    wb_line_master #(.TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
        .i_data(data), .i_strb(strb), .o_busy(busy), .o_done(done), .o_err(err),
        .o_data(odata), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_cti(wb_cti), .o_wb_bte(wb_bte), .o_wb_sel(wb_sel), .o_wb_addr(wb_addr),
        .o_wb_data(wb_wdata), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata)
    );

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  strb;
        int           first_ws;
        int           ws;
        int           err_beat;
        logic         noack;
        logic [127:0] rdata;
        logic         exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  cti;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] data;
    } beat_t;

    beat_t        exp_q[$];
    logic [127:0] exp_odata = '0;
    int           n_pass = 0;
    int           n_total = 0;

    int           s_first_ws = 0;
    int           s_ws = 0;
    int           s_err_beat = -1;
    logic         s_noack = 1'b0;
    logic         s_force = 1'b0;
    logic [127:0] s_rdata = '0;
    int           s_beat = 0;
    int           s_cnt = 0;
    int           done_cnt = 0;
    int           cyc_rise = 0;
    int           stb_gap = 0;
    logic         prev_cyc = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Slave: each beat waits its wait states then asserts ack (or ack+err on the error beat)
    initial begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
        wb_rdata = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (wb_cyc === 1'b1 && prev_cyc !== 1'b1) cyc_rise++;
            if (wb_cyc === 1'b1 && wb_stb !== 1'b1) stb_gap++;
            prev_cyc = wb_cyc;
            wb_ack = 1'b0;
            wb_err = 1'b0;
            if (s_force) begin
                wb_ack = 1'b1;
                wb_err = 1'b1;
            end else if (wb_cyc !== 1'b1) begin
                s_beat = 0;
                s_cnt = 0;
            end else if (wb_stb === 1'b1 && !rst && !s_noack) begin
                if (s_cnt < ((s_beat == 0) ? s_first_ws : s_ws)) begin
                    s_cnt++;
                end else begin
                    beat_t e;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("beat%0d", s_beat),
                              {wb_addr, wb_cti, wb_sel, wb_we, wb_we ? wb_wdata : 32'h0},
                              {e.addr, e.cti, e.sel, e.we, e.data});
                    end
                    wb_ack = 1'b1;
                    if (s_beat == s_err_beat) begin
                        wb_err = 1'b1;
                        wb_rdata = 32'hDEAD_BEEF;
                    end else begin
                        wb_rdata = s_rdata[32*s_beat +: 32];
                    end
                    s_beat++;
                    s_cnt = 0;
                end
            end
        end
    end

    task automatic push_exp(input vec_t v, output int exp_lat, output logic [127:0] exp_d);
        beat_t e;
        int last, need;
        last = v.noack ? -1 : ((v.err_beat >= 0) ? v.err_beat : 3);
        exp_lat = v.noack ? 1 + TMO : 1;
        exp_d = exp_odata;
        for (int b = 0; b <= last; b++) begin
            need = (b == 0) ? v.first_ws : v.ws;
            exp_lat += need + 1;
            e.addr = {v.addr[31:4], 4'(b * 4)};
            e.cti  = (b == 3) ? 3'b111 : 3'b010;
            e.sel  = v.we ? v.strb[4*b +: 4] : 4'hF;
            e.we   = v.we;
            e.data = v.we ? v.wdata[32*b +: 32] : 32'h0;
            exp_q.push_back(e);
            if (!v.we && b != v.err_beat) exp_d[32*b +: 32] = v.rdata[32*b +: 32];
        end
    endtask

    task automatic drive_req(input vec_t v);
        s_first_ws = v.first_ws;
        s_ws = v.ws;
        s_err_beat = v.err_beat;
        s_noack = v.noack;
        s_rdata = v.rdata;
        req = 1'b1;
        we = v.we;
        addr = v.addr;
        data = v.wdata;
        strb = v.strb;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat, exp_lat, d0, g0;
        logic [127:0] exp_d;
        push_exp(v, exp_lat, exp_d);
        d0 = done_cnt;
        g0 = stb_gap;
        @(negedge clk);
        drive_req(v);
        @(negedge clk);
        req = 1'b0;
        check({tag, "_accept"}, {wb_cyc, wb_stb, busy, wb_we, wb_addr},
              {3'b111, v.we, v.addr[31:4], 4'h0});
        lat = 1;
        while (done !== 1'b1 && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_done"}, {done, err, busy, wb_cyc, wb_stb, wb_cti},
              {1'b1, v.exp_err, 3'b000, 3'b000});
        check({tag, "_odata"}, odata, exp_d);
        exp_odata = exp_d;
        @(negedge clk);
        check({tag, "_pulse"}, {done, busy, wb_cyc}, 3'b000);
        @(negedge clk);
        check({tag, "_counts"}, {done_cnt - d0, stb_gap - g0, exp_q.size()}, {32'd1, 32'd0, 32'd0});
        exp_q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        int lat, exp_lat, d0, c0;
        logic [127:0] exp_d;
        vec_t v;

        vecs[0] = '{we: 1'b0, addr: 32'h0000_1238, wdata: '0, strb: '0, first_ws: 1, ws: 0,
                    err_beat: -1, noack: 1'b0,
                    rdata: 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, exp_err: 1'b0};
        vecs[1] = '{we: 1'b1, addr: 32'h0000_4004, wdata: 128'h57575757_56565656_55555555_54545454,
                    strb: 16'hF00F, first_ws: 2, ws: 2, err_beat: -1, noack: 1'b0,
                    rdata: '0, exp_err: 1'b0};
        vecs[2] = '{we: 1'b0, addr: 32'h0000_8000, wdata: '0, strb: '0, first_ws: 0, ws: 0,
                    err_beat: 2, noack: 1'b0,
                    rdata: 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, exp_err: 1'b1};
        vecs[3] = '{we: 1'b0, addr: 32'h0000_C000, wdata: '0, strb: '0, first_ws: 0, ws: 0,
                    err_beat: -1, noack: 1'b1, rdata: '1, exp_err: 1'b1};
        vecs[4] = '{we: 1'b1, addr: 32'hFFFF_FFF0, wdata: 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A,
                    strb: 16'h0000, first_ws: 1, ws: 1, err_beat: -1, noack: 1'b0,
                    rdata: '0, exp_err: 1'b0};
        vecs[5] = '{we: 1'b0, addr: 32'hFFFF_FFFC, wdata: '0, strb: '0, first_ws: 3, ws: 1,
                    err_beat: -1, noack: 1'b0,
                    rdata: 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, exp_err: 1'b0};

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; data = '0; strb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", {wb_cyc, wb_stb, wb_we, busy, done, err}, 6'b0);
        check("reset_bus", {wb_cti, wb_bte, wb_sel, wb_addr, wb_wdata}, '0);
        check("reset_odata", odata, '0);

        // ack/err with stb low must not start or finish anything
        d0 = done_cnt;
        s_force = 1'b1;
        repeat (3) @(negedge clk);
        s_force = 1'b0;
        @(negedge clk);
        check("idle_ack_ignored", {busy, err, wb_cyc, done_cnt - d0}, '0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // reset in the middle of beat 1
        v = vecs[0];
        v.first_ws = 0;
        v.ws = 3;
        push_exp(v, exp_lat, exp_d);
        d0 = done_cnt;
        @(negedge clk);
        drive_req(v);
        @(negedge clk);
        req = 1'b0;
        lat = 0;
        while (s_beat != 1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("rst_reach_beat1", {wb_cyc, lat < 100}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_burst", {wb_cyc, wb_stb, busy, done}, 4'b0);
        exp_q.delete();
        exp_odata = '0;
        repeat (3) @(negedge clk);
        check("rst_no_done", {done_cnt - d0, odata}, '0);
        run_vec(vecs[5], "after_rst");

        // i_req pulsed during BURST and during DONE; held req starts the next burst
        v = vecs[0];
        v.ws = 1;
        push_exp(v, exp_lat, exp_d);
        c0 = cyc_rise;
        @(negedge clk);
        drive_req(v);
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        req = 1'b1;
        addr = 32'h0000_9990;
        @(negedge clk);
        req = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("req_busy_done", {done, err, cyc_rise - c0}, {2'b10, 32'd1});
        check("req_busy_odata", odata, exp_d);
        exp_odata = exp_d;
        check("req_busy_queue", exp_q.size(), 0);
        v = vecs[2];
        v.err_beat = -1;
        v.exp_err = 1'b0;
        push_exp(v, exp_lat, exp_d);
        drive_req(v);
        @(negedge clk);
        check("req_in_done_ignored", {wb_cyc, busy, done}, 3'b000);
        @(negedge clk);
        req = 1'b0;
        check("req_held_accept", {wb_cyc, wb_stb, busy, wb_addr}, {3'b111, 32'h0000_8000});
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("second_burst", {done, err, odata}, {2'b10, exp_d});
        @(negedge clk);
        check("second_counts", {cyc_rise - c0, exp_q.size()}, {32'd2, 32'd0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
